// File: rtl/gb_wave_ram.sv
// gb_wave_ram: channel 3 wave pattern RAM with CPU access redirected or blocked while the channel is playing
module gb_wave_ram #(
    parameter int FETCH_WINDOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    input  logic       on,
    input  logic [3:0] wave_addr,
    output logic [7:0] wave_data
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state;
    logic [7:0] mem [16];
    logic [3:0] prev_addr;
    logic       on_d;
    logic [2:0] win_cnt;
    logic       fetch;
    logic       accept;
    logic       blocked;
    logic       wr;
    logic [3:0] eff_addr;

    assign fetch    = on & ((wave_addr != prev_addr) | ~on_d);
    assign accept   = (state == IDLE) & cpu_req;
    assign blocked  = on & (win_cnt == 3'd0);
    assign eff_addr = on ? wave_addr : cpu_addr;
    assign wr       = accept & cpu_we & ~blocked;

    // Track the channel address and on flag to spot fetches, and run the post-fetch window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_addr <= 4'd0;
            on_d      <= 1'b0;
            win_cnt   <= 3'd0;
        end else begin
            prev_addr <= wave_addr;
            on_d      <= on;
            win_cnt   <= !on ? 3'd0 : fetch ? 3'(FETCH_WINDOW) : (win_cnt != 3'd0) ? win_cnt - 3'd1 : 3'd0;
        end
    end

    // Commit CPU writes that were not blocked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (wr) begin
            mem[eff_addr] <= cpu_wdata;
        end
    end

    // Channel read port; a same-edge write to the fetched byte is passed straight through
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave_data <= 8'h00;
        end else if (!on || fetch) begin
            wave_data <= (wr && eff_addr == wave_addr) ? cpu_wdata : mem[wave_addr];
        end
    end

    // CPU handshake: accept in IDLE, ack for exactly one cycle, ignore requests while acking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'hFF;
        end else if (state == IDLE) begin
            state   <= cpu_req ? ACK : IDLE;
            cpu_ack <= cpu_req;
            if (accept && !cpu_we) cpu_rdata <= blocked ? 8'hFF : mem[eff_addr];
        end else begin
            state   <= IDLE;
            cpu_ack <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gb_wave_ram.sv
// tb_gb_wave_ram: directed plan plus randomized traffic checked against a cycle-indexed reference model
module tb_gb_wave_ram;
    localparam int FW = 2;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [3:0] cpu_addr = 4'd0;
    logic [7:0] cpu_wdata = 8'd0;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic       on = 1'b0;
    logic [3:0] wave_addr = 4'd0;
    logic [7:0] wave_data;
    int total = 0;
    int passed = 0;
    logic [7:0] m_mem [16];
    logic [7:0] m_wave;
    logic [7:0] m_rdata;
    logic       m_ack;
    logic [3:0] m_prev;
    logic       m_on_prev;
    int         cyc;
    int         last_fetch;

    always #5 clk = ~clk;

    gb_wave_ram #(.FETCH_WINDOW(FW)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .on(on), .wave_addr(wave_addr), .wave_data(wave_data)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_wave = 8'h00;
        m_rdata = 8'hFF;
        m_ack = 1'b0;
        m_prev = 4'd0;
        m_on_prev = 1'b0;
        cyc = 0;
        last_fetch = -1000;
    endtask

    // Model one clock from the current inputs, clock the DUT, then compare all outputs
    task automatic tick();
        logic fetch, win, blocked, wr, rd;
        logic [3:0] a;
        logic [7:0] nw;
        fetch = on && (wave_addr != m_prev || !m_on_prev);
        win = on && (cyc - last_fetch >= 1) && (cyc - last_fetch <= FW);
        blocked = on && !win;
        a = on ? wave_addr : cpu_addr;
        rd = !m_ack && cpu_req && !cpu_we;
        wr = !m_ack && cpu_req && cpu_we && !blocked;
        nw = m_wave;
        if (!on || fetch) nw = (wr && a == wave_addr) ? cpu_wdata : m_mem[wave_addr];
        if (rd) m_rdata = blocked ? 8'hFF : m_mem[a];
        if (wr) m_mem[a] = cpu_wdata;
        m_ack = !m_ack && cpu_req;
        m_wave = nw;
        if (fetch) last_fetch = cyc;
        if (!on) last_fetch = -1000;
        m_prev = wave_addr;
        m_on_prev = on;
        cyc++;
        @(posedge clk);
        #1;
        chk("ack", {7'd0, cpu_ack}, {7'd0, m_ack});
        chk("rdata", cpu_rdata, m_rdata);
        chk("wave", wave_data, m_wave);
    endtask

    task automatic access(input logic we, input logic [3:0] addr, input logic [7:0] data);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = data;
        tick();
        cpu_req = 1'b0;
        chk("ack_latency", {7'd0, cpu_ack}, 8'd1);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_ack", {7'd0, cpu_ack}, 8'd0);
        chk("rst_rdata", cpu_rdata, 8'hFF);
        chk("rst_wave", wave_data, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // CPU write/read with the channel off, then channel port sees the byte
        access(1'b1, 4'd3, 8'hA5);
        tick();
        access(1'b0, 4'd3, 8'h00);
        chk("plan_rd3", cpu_rdata, 8'hA5);
        tick();
        chk("rdata_hold", cpu_rdata, 8'hA5);
        wave_addr = 4'd3;
        tick();
        chk("plan_wave3", wave_data, 8'hA5);

        // Fetch of byte 5 then redirected read of addr 9
        access(1'b1, 4'd5, 8'h3C);
        tick();
        wave_addr = 4'd4;
        on = 1'b1;
        tick();
        tick();
        tick();
        tick();
        wave_addr = 4'd5;
        tick();
        chk("plan_fetch5", wave_data, 8'h3C);
        access(1'b0, 4'd9, 8'h00);
        chk("plan_redirect", cpu_rdata, 8'h3C);
        tick();

        // No fetch for a while: accesses are blocked
        repeat (10) tick();
        access(1'b0, 4'd2, 8'h00);
        chk("plan_blocked_rd", cpu_rdata, 8'hFF);
        tick();
        access(1'b1, 4'd2, 8'h77);
        tick();
        on = 1'b0;
        tick();
        access(1'b0, 4'd2, 8'h00);
        chk("plan_blocked_wr", cpu_rdata, 8'h00);
        tick();

        // Write in the window of a fetch of byte 7 lands in byte 7
        on = 1'b1;
        wave_addr = 4'd7;
        tick();
        access(1'b1, 4'd0, 8'h5A);
        tick();
        on = 1'b0;
        tick();
        access(1'b0, 4'd7, 8'h00);
        chk("plan_win_wr7", cpu_rdata, 8'h5A);
        tick();
        access(1'b0, 4'd0, 8'h00);
        chk("plan_win_wr0", cpu_rdata, 8'h00);
        tick();

        // Same-edge write-through to the channel port
        wave_addr = 4'd1;
        tick();
        access(1'b1, 4'd1, 8'hE1);
        chk("plan_collision", wave_data, 8'hE1);
        tick();

        // Randomized traffic, including on toggles and address wrap
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) on = ~on;
            if ($urandom_range(0, 2) == 0) wave_addr = ($urandom_range(0, 1) == 0) ? wave_addr + 4'd1 : 4'($urandom);
            cpu_req = $urandom_range(0, 1) == 1;
            cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = 4'($urandom);
            cpu_wdata = 8'($urandom);
            tick();
        end
        cpu_req = 1'b0;
        on = 1'b0;
        tick();

        // Read back every byte with unrestricted access
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 4'(i), 8'h00);
            chk("dump", cpu_rdata, m_mem[i]);
            tick();
        end

        // Reset in the ACK cycle aborts the access
        access(1'b0, 4'd7, 8'h00);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_ack", {7'd0, cpu_ack}, 8'd0);
        chk("rst_mid_wave", wave_data, 8'h00);
        chk("rst_mid_rdata", cpu_rdata, 8'hFF);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        access(1'b0, 4'd0, 8'h00);
        chk("post_rst_rd0", cpu_rdata, 8'h00);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gb_wave_ram.md
# gb_wave_ram

Wave pattern RAM for APU channel 3: 16 bytes of storage holding 32 4-bit samples at CPU addresses 0xFF30–0xFF3F. The block serves the CPU bus on one side and the custom-wave channel's sample fetch port on the other. While the channel is playing, it enforces DMG access rules: CPU accesses are redirected to the byte being fetched, or blocked. It sits between the APU register decoder and the channel 3 generator.

## Interface
- FETCH_WINDOW, default 2: number of clocks after a channel fetch during which CPU accesses are redirected rather than blocked; legal range 1–7.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  single-cycle CPU access request (address already decoded to 0xFF30–0xFF3F).
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  4  byte index (address low nibble).
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data, valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- on  in  1  channel 3 DAC/playing flag.
- wave_addr  in  4  byte index requested by the channel.
- wave_data  out  8  registered byte for the channel.

## Operation
- Storage: mem[0:15], 8 bits each.
- Fetch detection:
  - Register prev_addr <= wave_addr every clock.
  - fetch = on & ((wave_addr != prev_addr) | rising edge of on).
- Window counter win_cnt, 3 bits:
  - fetch loads FETCH_WINDOW.
  - Otherwise it decrements while nonzero.
  - on = 0 forces 0.
- Channel read port:
  - on = 0: wave_data <= mem[wave_addr] every clock.
  - on = 1: wave_data updates only on fetch; otherwise it holds.
- CPU FSM, states IDLE and ACK.
  - IDLE, cpu_req = 1:
    - Resolve the effective access in the same cycle.
    - Go to ACK.
  - ACK:
    - cpu_ack = 1 and cpu_rdata is valid.
    - Go to IDLE unconditionally.
    - cpu_req in ACK is ignored; no queueing.
- Effective access, decided in the request cycle:
  - on = 0: address = cpu_addr.
  - on = 1 and win_cnt != 0: address = wave_addr; cpu_addr is ignored.
  - on = 1 and win_cnt = 0: blocked.
    - Reads return 0xFF.
    - Writes are dropped.
    - The ack is still issued.
- Writes commit to mem at the clock edge ending the request cycle.
- A read captures mem[effective address] at that same edge.
- Same-edge collision: when a CPU write and a wave_data load target the same byte, wave_data receives cpu_wdata (write-through).

## Timing
- Reset (reset = 0, asynchronous):
  - mem all 0x00, wave_data = 0x00.
  - cpu_rdata = 0xFF, cpu_ack = 0.
  - FSM = IDLE, win_cnt = 0, prev_addr = 0.
- Release of reset is synchronous to clk. Reset asserted mid-access aborts the access with no ack and no write.
- CPU latency: cpu_req at cycle N produces cpu_ack at cycle N+1. Maximum throughput is one access per 2 clocks.
- cpu_rdata holds its last value after the ack.
- Channel latency: fetch at cycle N produces new wave_data at cycle N+1.
- Window: fetch at cycle N gives win_cnt = FETCH_WINDOW at cycles N+1..N+FETCH_WINDOW (decreasing), and 0 at N+FETCH_WINDOW+1.
  - A CPU request in cycles N+1..N+FETCH_WINDOW is redirected.
  - A request in the fetch cycle N itself uses the pre-fetch win_cnt.
- on falling mid-window clears win_cnt next clock. Unrestricted access resumes from that clock.
- wave_addr wrapping 15→0 is an ordinary address change and counts as a fetch.

## Test plan
- Reset then on = 0: write 0xA5 to addr 3, read addr 3 → cpu_ack one cycle after req, cpu_rdata = 0xA5. Set wave_addr = 3 → wave_data = 0xA5 the next clock.
- on = 1, wave_addr steps 4→5 at cycle N with mem[5] = 0x3C → wave_data = 0x3C at N+1. CPU read of addr 9 at N+1 returns 0x3C (redirected).
- on = 1, no fetch for 10 clocks: read addr 2 → 0xFF. Write 0x77 to addr 2 → mem[2] unchanged, verified after on = 0.
- on = 1, CPU write 0x5A issued in the window of a fetch of addr 7 → mem[7] = 0x5A. The rest of mem is unchanged.
- Collision: on = 0, wave_addr = 1, CPU write 0xE1 to addr 1 → wave_data = 0xE1 on the same edge as the memory update.
- Assert reset during ACK state → cpu_ack drops immediately, wave_data = 0x00. After release, read addr 0 → 0x00.
